// File: rtl/receiver_uart_pkg.sv
// rtl/receiver_uart_pkg.sv - shared SOC IO constants and UART receiver FSM encoding
package receiver_uart_pkg;

  // IO page bit selects
  localparam int IO_LEDS_bit      = 0;
  localparam int IO_UART_DAT_bit  = 1;
  localparam int IO_UART_CNTL_bit = 2;
  localparam int IO_UART_RX_bit   = 3;

  // Status bit positions in the IO_UART_CNTL word
  localparam int UART_CNTL_TX_BUSY_bit   = 9;
  localparam int UART_CNTL_RX_VALID_bit  = 8;
  localparam int UART_CNTL_OVERRUN_bit   = 7;
  localparam int UART_CNTL_FRAME_ERR_bit = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/receiver_uart_rx_fifo.sv
// rtl/receiver_uart_rx_fifo.sv - first-word-fall-through FIFO for received bytes
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign data    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/receiver_uart.sv
// rtl/receiver_uart.sv - 8N1 UART receiver with FWFT byte FIFO and sticky error flags
module receiver_uart
  import receiver_uart_pkg::*;
#(
  parameter int clk_divider = 8,
  parameter int DEPTH       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_overrun,
  output logic       o_frame_err,
  input  logic       i_clr_err
);

  localparam int HALF = clk_divider / 2;
  localparam int CW   = $clog2(clk_divider);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(clk_divider - 1);

  logic          rx_meta;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          stop_sample;
  logic          pop;
  logic          fifo_full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic          unused_count;

  assign stop_sample  = (state == ST_STOP) && (cnt == BIT_LAST);
  assign pop          = o_valid & i_ready;
  assign o_busy       = (state != ST_IDLE);
  assign unused_count = ^fifo_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          // Mid-start-bit check rejects short glitches on the idle line.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (stop_sample && rx_s && fifo_full && !pop) begin
        o_overrun <= 1'b1;
      end else if (i_clr_err) begin
        o_overrun <= 1'b0;
      end
      if (stop_sample && !rx_s) begin
        o_frame_err <= 1'b1;
      end else if (i_clr_err) begin
        o_frame_err <= 1'b0;
      end
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (stop_sample & rx_s),
    .push_data (shift),
    .pop       (pop),
    .data      (o_data),
    .valid     (o_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_receiver_uart.sv
// tb/tb_receiver_uart.sv - scoreboard bench for receiver_uart
module tb_receiver_uart;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_overrun;
  logic       o_frame_err;
  logic       i_clr_err;

  int         passed = 0;
  int         total  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  receiver_uart #(
    .clk_divider (8),
    .DEPTH       (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_frame_err (o_frame_err),
    .i_clr_err   (i_clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    tick(8);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      tick(8);
    end
    i_rx = stop;
    tick(8);
    i_rx = 1'b1;
  endtask

  // Monitor: every accepted pop must match the oldest expected byte
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL pop_unexpected: got %0h expected no data", o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", {24'd0, o_data}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0; i_clr_err = 1'b0;
    tick(3);
    i_rst = 1'b0;
    tick(1);
    check("rst_data", {24'd0, o_data}, 32'h0);
    check("rst_valid", {31'd0, o_valid}, 32'h0);
    check("rst_busy", {31'd0, o_busy}, 32'h0);
    check("rst_overrun", {31'd0, o_overrun}, 32'h0);
    check("rst_frame_err", {31'd0, o_frame_err}, 32'h0);

    // Single frame 0xA5: valid rises exactly at E+79
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        tick(78);
        #1;
        check("a5_valid_e78", {31'd0, o_valid}, 32'h0);
        check("a5_busy_e78", {31'd0, o_busy}, 32'h1);
        tick(1);
        #1;
        check("a5_valid_e79", {31'd0, o_valid}, 32'h1);
        check("a5_data_e79", {24'd0, o_data}, 32'hA5);
        check("a5_busy_e79", {31'd0, o_busy}, 32'h0);
      end
    join
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    check("a5_valid_after_pop", {31'd0, o_valid}, 32'h0);
    check("a5_data_after_pop", {24'd0, o_data}, 32'h0);

    // Glitch on idle line
    i_rx = 1'b0;
    tick(3);
    i_rx = 1'b1;
    tick(1);
    check("glitch_busy_high", {31'd0, o_busy}, 32'h1);
    tick(20);
    check("glitch_busy_low", {31'd0, o_busy}, 32'h0);
    check("glitch_valid", {31'd0, o_valid}, 32'h0);
    check("glitch_overrun", {31'd0, o_overrun}, 32'h0);
    check("glitch_frame_err", {31'd0, o_frame_err}, 32'h0);

    // Framing error on 0x3C
    send_byte(8'h3C, 1'b0);
    tick(20);
    check("ferr_flag", {31'd0, o_frame_err}, 32'h1);
    check("ferr_valid", {31'd0, o_valid}, 32'h0);
    check("ferr_overrun", {31'd0, o_overrun}, 32'h0);
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    check("ferr_cleared", {31'd0, o_frame_err}, 32'h0);

    // Five back-to-back frames, no pops: fifth is dropped
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    tick(4);
    check("ovr_flag", {31'd0, o_overrun}, 32'h1);
    check("ovr_valid", {31'd0, o_valid}, 32'h1);
    check("ovr_frame_err", {31'd0, o_frame_err}, 32'h0);
    i_ready = 1'b1;
    tick(4);
    i_ready = 1'b0;
    check("ovr_drained_valid", {31'd0, o_valid}, 32'h0);
    check("ovr_queue_empty", exp_q.size(), 32'h0);
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    check("ovr_cleared", {31'd0, o_overrun}, 32'h0);

    // Full FIFO, pop coincides with fifth stop sample
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    exp_q.push_back(8'h05);
    fork
      send_byte(8'h05, 1'b1);
      begin
        tick(78);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
      end
    join
    tick(4);
    check("coinc_overrun", {31'd0, o_overrun}, 32'h0);
    check("coinc_valid", {31'd0, o_valid}, 32'h1);
    check("coinc_head", {24'd0, o_data}, 32'h02);
    i_ready = 1'b1;
    tick(4);
    i_ready = 1'b0;
    check("coinc_drained_valid", {31'd0, o_valid}, 32'h0);
    check("coinc_queue_empty", exp_q.size(), 32'h0);

    // Reset during data bit 4 of 0xFF, then clean 0x5A
    i_rx = 1'b0;
    tick(8);
    for (int k = 0; k < 4; k++) begin
      i_rx = 1'b1;
      tick(8);
    end
    tick(3);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check("mrst_busy", {31'd0, o_busy}, 32'h0);
    check("mrst_valid", {31'd0, o_valid}, 32'h0);
    tick(40);
    check("mrst_idle_busy", {31'd0, o_busy}, 32'h0);
    check("mrst_idle_valid", {31'd0, o_valid}, 32'h0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    tick(3);
    check("mrst_5a_valid", {31'd0, o_valid}, 32'h1);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    tick(2);
    check("mrst_overrun", {31'd0, o_overrun}, 32'h0);
    check("mrst_frame_err", {31'd0, o_frame_err}, 32'h0);
    check("mrst_final_valid", {31'd0, o_valid}, 32'h0);
    check("final_queue_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/receiver_uart.md
# receiver_uart

Serial 8N1 UART receiver, the inbound counterpart of the SOC's UART emitter. It samples the `RXD` pin, reassembles bytes LSB-first and queues them in a small first-word-fall-through FIFO. The CPU reads them through the IO page with a valid/ready pop handshake. It also reports sticky overrun and framing-error flags to the IO status word.

## Interface
- `clk_divider`, default 8: clocks per bit period; must be ≥4. Bit rate = `i_clk` frequency / `clk_divider`. Must match the emitter's setting.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `i_clk  in  1`: sole clock.
- `i_rst  in  1`: synchronous, active-high reset.
- `i_rx  in  1`: asynchronous serial line; idles high.
- `o_data  out  8`: FIFO head byte; 8'h00 when FIFO empty.
- `o_valid  out  1`: FIFO not empty.
- `i_ready  in  1`: pop request; a pop occurs on a cycle with `o_valid & i_ready`.
- `o_busy  out  1`: FSM not in IDLE.
- `o_overrun  out  1`: sticky; a completed byte was dropped because the FIFO was full.
- `o_frame_err  out  1`: sticky; a stop bit was sampled low.
- `i_clr_err  in  1`: one-cycle pulse; clears both sticky flags.

## Operation
- **Synchronizer:** `i_rx` passes through 2 flops, giving `rx_s`; both flops reset to 1.
- **Constants:** HALF = `clk_divider`/2 (integer). Bit counter is wide enough for `clk_divider`-1; bit index is 3 bits.
- **IDLE:** when `rx_s`==0, go to START and clear the counter. Call this cycle D.
- **START:** at D+HALF, sample `rx_s`.
  - 1: glitch; return to IDLE with nothing recorded.
  - 0: go to DATA with counter cleared and bit index 0.
- **DATA:** every `clk_divider` cycles, sample `rx_s` into shift-reg bit[index], LSB first. After the 8th sample, go to STOP.
- **STOP:** `clk_divider` cycles after the last data sample, sample `rx_s`, then go to IDLE on the next cycle. No wait for the end of the stop bit, so back-to-back frames are accepted.
  - 1: push the byte. If FIFO full and no pop this cycle, drop the byte and set `o_overrun`.
  - 0: discard the byte and set `o_frame_err`.
- **Simultaneous push and pop when full:** both succeed; count unchanged; no overrun.
- **Simultaneous push and pop when count==1:** head advances to the new byte; `o_valid` stays 1.
- **Simultaneous flag set and `i_clr_err` in one cycle:** set wins.
- **Pointers:** wrap modulo `DEPTH`. Count is 0..`DEPTH`. Full when count==`DEPTH`.
- **Reset mid-frame:** FSM to IDLE, FIFO flushed, flags cleared, shift register cleared. Partial bytes are never pushed.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_busy`=0, `o_overrun`=0, `o_frame_err`=0.
- Line-to-D latency: 2 cycles (synchronizer). The first low input cycle is E, so D = E+2.
- Samples:
  - start at D+HALF;
  - data bit k (k=0..7) at D+HALF+(k+1)·`clk_divider`;
  - stop at D+HALF+9·`clk_divider`.
- `o_valid` rises and `o_data` is valid at D+HALF+9·`clk_divider`+1.
- `o_busy` is high from D+1 through the cycle of the stop sample.
- Pop: `o_data`/`o_valid` update on the cycle after the pop.
- Sticky flags assert on the cycle after the offending stop sample.
- Sustained throughput: one byte per 10·`clk_divider` cycles with no loss, provided software pops at least once per frame on average.

## Structure
- Shared SOC IO include or package holds:
  - IO bit constants: existing `IO_LEDS_bit`=0, `IO_UART_DAT_bit`=1, `IO_UART_CNTL_bit`=2; new `IO_UART_RX_bit`=3 for read-data/pop;
  - status bit positions in the `IO_UART_CNTL` word: bit 9 TX busy (existing); bit 8 RX valid, bit 7 overrun, bit 6 frame error (new);
  - the FSM state encoding (IDLE, START, DATA, STOP).
- One sub-module, `rx_fifo`: parameterised FWFT FIFO (push, pop, data, valid, full, count). The FSM, synchronizer and flags stay in `receiver_uart`.

## Test plan
All scenarios use `clk_divider`=8, `DEPTH`=4.
- Single frame 0xA5, one valid stop bit, `i_ready`=0 → `o_valid`=1 at E+2+4+72+1 = E+79 with `o_data`=8'hA5. Hold `i_ready` high 1 cycle → `o_valid`=0 and `o_data`=0 next cycle.
- 3-cycle low glitch on idle line → start sample reads 1; `o_busy` returns 0; `o_valid` never rises; no flags set.
- Frame 0x3C with stop bit driven 0 → `o_frame_err`=1, `o_valid`=0. `i_clr_err` pulse → flag 0 next cycle.
- Five back-to-back frames 0x01..0x05, no pops → FIFO holds 0x01..0x04, `o_overrun`=1. Popping 4 times yields 0x01, 0x02, 0x03, 0x04 in order, then `o_valid`=0.
- FIFO full, 5th frame's stop sample coincides with a pop → no overrun; final contents 0x02..0x05.
- `i_rst` asserted during data bit 4 of 0xFF, then a clean 0x5A frame → 0xFF never appears; 0x5A received; flags remain 0.
